// File: rtl/array_feeder.sv
// array_feeder: input/control sequencer and operand skewer for the systolic array.
// It accepts operand beats over valid/ready and drives skewed en/clr/data lanes.
// After the reduction it flushes the array and issues the column drain enables.
// Optional build macro: ARRAY_FEEDER_PERF_EN adds the perf_stall_cnt output.
module array_feeder #(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int IWIDTH = 8,
    parameter int KW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [HEIGHT*IWIDTH-1:0] in_ifm,
    input  logic [WIDTH*IWIDTH-1:0]  in_wght,
    output logic [HEIGHT-1:0]        en_i,
    output logic [HEIGHT-1:0]        clr_i,
    output logic [WIDTH-1:0]         en_w,
    output logic [WIDTH-1:0]         clr_w,
    output logic [WIDTH-1:0]         en_o,
    output logic [WIDTH-1:0]         clr_o,
    output logic [HEIGHT*IWIDTH-1:0] ifm,
    output logic [WIDTH*IWIDTH-1:0]  wght
`ifdef ARRAY_FEEDER_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    // FLUSH lets the last beat reach the far corner; DRAIN shifts every column sum out.
    localparam int FLUSH_LEN  = HEIGHT + WIDTH - 2;
    localparam int DRAIN_LAST = HEIGHT + WIDTH - 2;
    localparam int CW         = $clog2(HEIGHT + WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              en;
        logic              clr;
        logic [IWIDTH-1:0] data;
    } row_lane_t;

    typedef struct packed {
        logic              en;
        logic              clr;
        logic              en_o;
        logic              clr_o;
        logic [IWIDTH-1:0] data;
    } col_lane_t;

    state_t        state_q, state_d;
    logic [KW-1:0] beats_q, beats_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zdone_q, zdone_d;

    // Unskewed lane values produced by the FSM for the current cycle.
    logic                     b_en;
    logic                     b_clr;
    logic                     b_en_o;
    logic                     b_clr_o;
    logic [HEIGHT*IWIDTH-1:0] b_ifm;
    logic [WIDTH*IWIDTH-1:0]  b_wght;

    // State, beat counter, phase counter and zero-length done flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beats_q <= '0;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            state_q <= state_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
        end
    end

    // Next-state logic and the unskewed base lane values.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d  = state_q;
        beats_d  = beats_q;
        cnt_d    = cnt_q;
        zdone_d  = 1'b0;
        b_en     = 1'b0;
        b_clr    = 1'b0;
        b_en_o   = 1'b0;
        b_clr_o  = 1'b0;
        b_ifm    = '0;
        b_wght   = '0;
        in_ready = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE) || zdone_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d = S_CLEAR;
                        beats_d = k_len;
                    end else begin
                        // Empty reduction: report completion without leaving IDLE.
                        zdone_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                b_clr   = 1'b1;
                b_clr_o = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                in_ready = (beats_q != '0);
                if (in_valid && in_ready) begin
                    b_en    = 1'b1;
                    b_ifm   = in_ifm;
                    b_wght  = in_wght;
                    beats_d = beats_q - KW'(1);
                    if (beats_q == KW'(1)) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == CW'(FLUSH_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                b_en_o = (cnt_q < CW'(HEIGHT));
                if (cnt_q == CW'(DRAIN_LAST)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Row lane h: {en, clr, data} delayed h+1 cycles.
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        row_lane_t sr_q [0:h];
        row_lane_t sr_d [0:h];

        // Shift the row bundle one stage per cycle.
        always_comb begin
            sr_d[0].en   = b_en;
            sr_d[0].clr  = b_clr;
            sr_d[0].data = b_ifm[h*IWIDTH +: IWIDTH];
            for (int s = 1; s <= h; s++) begin
                sr_d[s] = sr_q[s-1];
            end
        end

        // Row delay-line registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: the delay lines are reset so no stale enable or clear reaches the array.
                for (int s = 0; s <= h; s++) begin
                    sr_q[s] <= '0;
                end
            end else begin
                sr_q <= sr_d;
            end
        end

        assign en_i[h]                  = sr_q[h].en;
        assign clr_i[h]                 = sr_q[h].clr;
        assign ifm[h*IWIDTH +: IWIDTH]  = sr_q[h].data;
    end

    // Column lane w: {en, clr, en_o, clr_o, data} delayed w+1 cycles.
    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        col_lane_t sr_q [0:w];
        col_lane_t sr_d [0:w];

        // Shift the column bundle one stage per cycle.
        always_comb begin
            sr_d[0].en    = b_en;
            sr_d[0].clr   = b_clr;
            sr_d[0].en_o  = b_en_o;
            sr_d[0].clr_o = b_clr_o;
            sr_d[0].data  = b_wght[w*IWIDTH +: IWIDTH];
            for (int s = 1; s <= w; s++) begin
                sr_d[s] = sr_q[s-1];
            end
        end

        // Column delay-line registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= w; s++) begin
                    sr_q[s] <= '0;
                end
            end else begin
                sr_q <= sr_d;
            end
        end

        assign en_w[w]                  = sr_q[w].en;
        assign clr_w[w]                 = sr_q[w].clr;
        assign en_o[w]                  = sr_q[w].en_o;
        assign clr_o[w]                 = sr_q[w].clr_o;
        assign wght[w*IWIDTH +: IWIDTH] = sr_q[w].data;
    end

`ifdef ARRAY_FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of STREAM cycles where the feeder waited on in_valid.
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && start) begin
            perf_d = '0;
        end else if (in_ready && !in_valid && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_array_feeder.sv
// tb_array_feeder: directed bench for array_feeder with a beat scoreboard.
// Accepted beats are queued when driven and matched against the skewed lanes.
// Build with ARRAY_FEEDER_PERF_EN defined to also check perf_stall_cnt.
module tb_array_feeder;

    localparam int H     = 12;
    localparam int W     = 14;
    localparam int IW    = 8;
    localparam int KW    = 8;
    localparam int FLUSH = H + W - 2;
    localparam int DRAIN = H + W - 1;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int              cyc;
        logic [H*IW-1:0] ifm;
        logic [W*IW-1:0] wght;
    } beat_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            in_valid;
    logic            in_ready;
    logic [H*IW-1:0] in_ifm;
    logic [W*IW-1:0] in_wght;
    logic [H-1:0]    en_i;
    logic [H-1:0]    clr_i;
    logic [W-1:0]    en_w;
    logic [W-1:0]    clr_w;
    logic [W-1:0]    en_o;
    logic [W-1:0]    clr_o;
    logic [H*IW-1:0] ifm;
    logic [W*IW-1:0] wght;
`ifdef ARRAY_FEEDER_PERF_EN
    logic [31:0]     perf_stall_cnt;
`endif

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    beat_t sb[$];

    array_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .busy     (busy),
        .done     (done),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ifm   (in_ifm),
        .in_wght  (in_wght),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .en_w     (en_w),
        .clr_w    (clr_w),
        .en_o     (en_o),
        .clr_o    (clr_o),
        .ifm      (ifm),
        .wght     (wght)
`ifdef ARRAY_FEEDER_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},     128'(busy),     128'(0));
        check({tag, ".done"},     128'(done),     128'(0));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(0));
        check({tag, ".en_i"},     128'(en_i),     128'(0));
        check({tag, ".clr_i"},    128'(clr_i),    128'(0));
        check({tag, ".en_w"},     128'(en_w),     128'(0));
        check({tag, ".clr_w"},    128'(clr_w),    128'(0));
        check({tag, ".en_o"},     128'(en_o),     128'(0));
        check({tag, ".clr_o"},    128'(clr_o),    128'(0));
        check({tag, ".ifm"},      128'(ifm),      128'(0));
        check({tag, ".wght"},     128'(wght),     128'(0));
`ifdef ARRAY_FEEDER_PERF_EN
        check({tag, ".perf"},     128'(perf_stall_cnt), 128'(0));
`endif
    endtask

    function automatic bit find_beat(input int t, output beat_t b);
        b = '{cyc: 0, ifm: '0, wght: '0};
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == t) begin
                b = sb[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One operation: start in local cycle 0; mask bit j forces in_valid low in
    // stream cycle j; abort_at >= 0 applies a 3-cycle reset in that cycle.
    task automatic run_op(input string name, input int k, input logic [63:0] mask,
                          input bit skew, input int abort_at);
        int    c           = 0;
        int    left        = k;
        bit    stream_on   = 1'b0;
        bit    hs;
        int    done_cyc    = (k == 0) ? 1 : NEVER;
        int    drain_start = NEVER;
        int    stalls      = 0;
        int    pulses      = 0;
        beat_t b;
        logic [H-1:0]    x_en_i, x_clr_i;
        logic [W-1:0]    x_en_w, x_clr_w, x_en_o, x_clr_o;
        logic [H*IW-1:0] x_ifm;
        logic [W*IW-1:0] x_wght;

        sb.delete();
        while (c <= done_cyc + 1) begin
            cyc   = c;
            start = (c == 0) || (k != 0 && c == done_cyc);
            k_len = KW'(k);
            if (c == 2 && k > 0) stream_on = 1'b1;
            hs = 1'b0;
            if (stream_on) begin
                in_valid = !mask[c-2];
                hs       = in_valid;
            end else begin
                in_valid = 1'b1;
            end
            for (int h = 0; h < H; h++) in_ifm[h*IW +: IW] = skew ? IW'(h + 1) : IW'($urandom);
            for (int w = 0; w < W; w++) in_wght[w*IW +: IW] = skew ? IW'(-(w + 1)) : IW'($urandom);
            if (hs) begin
                sb.push_back('{cyc: c, ifm: in_ifm, wght: in_wght});
                left--;
            end

            if (c == abort_at) begin
                rst      = 1'b1;
                start    = 1'b0;
                in_valid = 1'b0;
                #1;
                check_zero({name, ".rst_now"});
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    check_zero({name, ".rst_hold"});
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
                @(negedge clk);
                check_zero({name, ".rst_release"});
                @(posedge clk);
                #1;
                sb.delete();
                return;
            end

            @(negedge clk);
            x_en_i = '0; x_clr_i = '0; x_ifm = '0;
            x_en_w = '0; x_clr_w = '0; x_en_o = '0; x_clr_o = '0; x_wght = '0;
            for (int h = 0; h < H; h++) begin
                if (find_beat(c - 1 - h, b)) begin
                    x_en_i[h]          = 1'b1;
                    x_ifm[h*IW +: IW]  = b.ifm[h*IW +: IW];
                end
                if (k > 0 && c - 1 - h == 1) x_clr_i[h] = 1'b1;
            end
            for (int w = 0; w < W; w++) begin
                if (find_beat(c - 1 - w, b)) begin
                    x_en_w[w]          = 1'b1;
                    x_wght[w*IW +: IW] = b.wght[w*IW +: IW];
                end
                if (k > 0 && c - 1 - w == 1) begin
                    x_clr_w[w] = 1'b1;
                    x_clr_o[w] = 1'b1;
                end
                if (c - 1 - w >= drain_start && c - 1 - w < drain_start + H) x_en_o[w] = 1'b1;
            end
            check({name, ".busy"},     128'(busy),     128'(k > 0 && c >= 1 && c <= done_cyc));
            check({name, ".done"},     128'(done),     128'(c == done_cyc));
            check({name, ".in_ready"}, 128'(in_ready), 128'(stream_on));
            check({name, ".en_i"},     128'(en_i),     128'(x_en_i));
            check({name, ".clr_i"},    128'(clr_i),    128'(x_clr_i));
            check({name, ".ifm"},      128'(ifm),      128'(x_ifm));
            check({name, ".en_w"},     128'(en_w),     128'(x_en_w));
            check({name, ".clr_w"},    128'(clr_w),    128'(x_clr_w));
            check({name, ".wght"},     128'(wght),     128'(x_wght));
            check({name, ".en_o"},     128'(en_o),     128'(x_en_o));
            check({name, ".clr_o"},    128'(clr_o),    128'(x_clr_o));
`ifdef ARRAY_FEEDER_PERF_EN
            if (c >= 1) check({name, ".perf"}, 128'(perf_stall_cnt), 128'(stalls));
`endif
            if (en_i[0]) pulses++;
            if (stream_on && !in_valid) stalls++;
            if (hs && left == 0) begin
                stream_on   = 1'b0;
                drain_start = c + 1 + FLUSH;
                done_cyc    = drain_start + DRAIN;
            end
            while (sb.size() > 0 && sb[0].cyc < c - W) void'(sb.pop_front());
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        check({name, ".en_i0_pulses"}, 128'(pulses), 128'(k));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        in_ifm   = '0;
        in_wght  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // k=3, no stalls, row h = h+1 / column w = -(w+1): done lands in cycle 54.
        run_op("skew", 3, 64'h0, 1'b1, -1);
        // Stall in cycle 3 (stream index 1): done moves to cycle 55.
        run_op("stall", 3, 64'h2, 1'b0, -1);
        // Zero-length reduction: done in cycle 1 with nothing else active.
        run_op("k0", 0, 64'h0, 1'b0, -1);
        // Scattered stalls over a longer reduction.
        run_op("k7", 7, 64'h15, 1'b0, -1);
        // Reset mid-stream, then a start immediately after release.
        run_op("abort", 10, 64'h0, 1'b0, 6);
        run_op("after_rst", 3, 64'h0, 1'b1, -1);
        // Four beats with five stall cycles, then a fresh start clears the count.
        run_op("perf", 4, 64'h6B, 1'b0, -1);
        run_op("perf_clr", 2, 64'h0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
